// File: rtl/axi_lite_arbiter.sv
// Two-port arbiter that serialises simple requester transactions onto one AXI4-Lite master port.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; otherwise s0 has fixed priority.
module axi_lite_arbiter #(
  parameter logic [31:0] OFFSET = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        s0_req,
  input  logic        s0_we,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  output logic        s0_done,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_resp,

  input  logic        s1_req,
  input  logic        s1_we,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  output logic        s1_done,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_resp,

  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,

  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,

  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,

  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,

  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [1:0]        done_q, done_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic [1:0][1:0]   resp_q, resp_d;

  // Arbitration and selection of the winning requester's fields.
  logic              any_req;
  logic              gnt_sel;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic              aw_left;
  logic              w_left;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  always_comb begin
    any_req = s0_req | s1_req;
`ifdef ARB_ROUND_ROBIN_EN
    gnt_sel = (s0_req & s1_req) ? ~last_q : s1_req;
`else
    gnt_sel = ~s0_req;
`endif
    sel_we    = gnt_sel ? s1_we    : s0_we;
    sel_addr  = gnt_sel ? s1_addr  : s0_addr;
    sel_wdata = gnt_sel ? s1_wdata : s0_wdata;
    sel_wstrb = gnt_sel ? s1_wstrb : s0_wstrb;
  end

  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_left   = awvalid_q & ~m_awready;
    w_left    = wvalid_q & ~m_wready;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        // While done is high the requester has not yet seen it, so its req is still the old one.
        if (any_req && (done_q == 2'b00)) begin
          gnt_d     = gnt_sel;
          addr_d    = sel_addr - OFFSET;
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          arvalid_d = ~sel_we;
          awvalid_d = sel_we;
          wvalid_d  = sel_we;
          state_d   = sel_we ? WADDR : RADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_d    = gnt_sel;
`endif
        end
      end

      RADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (m_rvalid) begin
          rready_d       = 1'b0;
          rdata_d[gnt_q] = m_rdata;
          resp_d[gnt_q]  = m_rresp;
          done_d[gnt_q]  = 1'b1;
          state_d        = IDLE;
        end
      end

      WADDR: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (m_bvalid) begin
          bready_d      = 1'b0;
          resp_d[gnt_q] = m_bresp;
          done_d[gnt_q] = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer starts at s1 so that s0 wins the first contended grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

  assign s0_done   = done_q[0];
  assign s0_rdata  = rdata_q[0];
  assign s0_resp   = resp_q[0];
  assign s1_done   = done_q[1];
  assign s1_rdata  = rdata_q[1];
  assign s1_resp   = resp_q[1];

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter (OFFSET=32'h80); honours ARB_ROUND_ROBIN_EN.
module tb_axi_lite_arbiter;

  logic        clk;
  logic        rstn;
  logic        s0_req, s0_we, s1_req, s1_we;
  logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_done, s1_done;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_resp, s1_resp;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [2:0]  m_arprot, m_awprot;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_errs   = 0;

  axi_lite_arbiter #(.OFFSET(32'h80)) dut (
    .clk(clk), .rstn(rstn),
    .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_done(s0_done), .s0_rdata(s0_rdata), .s0_resp(s0_resp),
    .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_done(s1_done), .s1_rdata(s1_rdata), .s1_resp(s1_resp),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {arvalid, rready, awvalid, wvalid, bready, s1_done, s0_done}
  function automatic logic [6:0] hs();
    return {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, s1_done, s0_done};
  endfunction

  logic [1:0] order_exp [4];
  logic [1:0] got_port;
  bit         seen;

  initial begin
    rstn = 1'b0;
    {s0_req, s0_we, s1_req, s1_we} = '0;
    {s0_addr, s0_wdata, s1_addr, s1_wdata} = '0;
    {s0_wstrb, s1_wstrb} = '0;
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    m_rdata = '0; m_rresp = '0; m_bresp = '0;
`ifdef ARB_ROUND_ROBIN_EN
    order_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    order_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

    // Reset state
    tick(); tick();
    check("rst_hs", hs(), 7'b0);
    check("rst_rdata", {s0_rdata, s1_rdata}, 64'h0);
    check("rst_resp_prot", {s0_resp, s1_resp, m_arprot, m_awprot}, 10'h0);
    rstn = 1'b1;
    tick();

    // Zero-wait read on s0: 0x100 - 0x80 = 0x80
    s0_req = 1'b1; s0_we = 1'b0; s0_addr = 32'h100;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
    tick();
    check("rd_ar", {m_arvalid, m_araddr}, {1'b1, 32'h80});
    check("rd_hs0", hs(), 7'b1000000);
    tick();
    check("rd_hs1", hs(), 7'b0100000);
    tick();
    check("rd_done", hs(), 7'b0000001);
    check("rd_data", {s0_rdata, s0_resp}, {32'hDEADBEEF, 2'b00});
    s0_req = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    tick();
    check("rd_done_pulse", hs(), 7'b0);

    // s1 read with AR backpressure, ending with SLVERR
    s1_req = 1'b1; s1_we = 1'b0; s1_addr = 32'h200;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {hs(), m_araddr}, {7'b1000000, 32'h180});
      tick();
    end
    m_arready = 1'b1;
    tick();
    check("bp_ar_done", hs(), 7'b0100000);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b10;
    tick();
    check("err_done", hs(), 7'b0000010);
    check("err_s1", {s1_rdata, s1_resp}, {32'h12345678, 2'b10});
    check("err_s0_kept", {s0_rdata, s0_resp}, {32'hDEADBEEF, 2'b00});
    s1_req = 1'b0; m_rvalid = 1'b0;
    tick();

    // s1 write with skewed ready: aw one cycle late, w four cycles late; addr wraps
    s1_req = 1'b1; s1_we = 1'b1; s1_addr = 32'h40; s1_wdata = 32'hCAFEF00D; s1_wstrb = 4'b0101;
    tick();
    check("wr_aw", {m_awaddr, m_wdata, m_wstrb}, {32'hFFFFFFC0, 32'hCAFEF00D, 4'b0101});
    check("wr_hs0", hs(), 7'b0011000);
    tick();
    check("wr_hs1", hs(), 7'b0011000);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    check("wr_aw_first", hs(), 7'b0001000);
    tick();
    tick();
    check("wr_w_wait", {hs(), m_wdata, m_wstrb}, {7'b0001000, 32'hCAFEF00D, 4'b0101});
    m_wready = 1'b1;
    tick();
    m_wready = 1'b0;
    check("wr_bready", hs(), 7'b0000100);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick();
    check("wr_done", hs(), 7'b0000010);
    check("wr_s1", {s1_rdata, s1_resp}, {32'h12345678, 2'b00});
    s1_req = 1'b0; m_bvalid = 1'b0;
    tick();
    check("wr_done_pulse", hs(), 7'b0);

    // Contention: both ports hold read requests for four transactions
    s0_req = 1'b1; s0_we = 1'b0; s0_addr = 32'h300;
    s1_req = 1'b1; s1_we = 1'b0; s1_addr = 32'h400;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55AA55AA; m_rresp = 2'b00;
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      got_port = 2'd3;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        if (s0_done || s1_done) begin
          seen = 1'b1;
          got_port = s1_done ? 2'd1 : 2'd0;
          check("cont_one_done", {s0_done, s1_done} == 2'b11, 1'b0);
        end
      end
      if (t == 3) begin
        s0_req = 1'b0; s1_req = 1'b0;
      end
      check($sformatf("cont_grant%0d", t), got_port, order_exp[t]);
    end
    m_arready = 1'b0; m_rvalid = 1'b0;
    tick();
    check("cont_idle", hs(), 7'b0);

    // Asynchronous reset during WRESP, then a contended request must go to s0
    s0_req = 1'b1; s0_we = 1'b1; s0_addr = 32'h500; s0_wdata = 32'h01020304; s0_wstrb = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    tick();
    check("rst_in_wresp", hs(), 7'b0000100);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_hs", hs(), 7'b0);
    check("rst_async_data", {s0_rdata, s1_rdata}, 64'h0);
    check("rst_async_addr", {m_awaddr, m_wdata}, 64'h0);
    s0_req = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    #2 rstn = 1'b1;
    tick();
    check("post_rst_idle", hs(), 7'b0);
    s0_req = 1'b1; s0_we = 1'b0; s0_addr = 32'h600;
    s1_req = 1'b1; s1_we = 1'b0; s1_addr = 32'h700;
    m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0BADF00D; m_rresp = 2'b00;
    tick();
    check("post_rst_ar", {m_arvalid, m_araddr}, {1'b1, 32'h580});
    tick();
    tick();
    check("post_rst_done", hs(), 7'b0000001);
    check("post_rst_data", {s0_rdata, s1_rdata}, {32'h0BADF00D, 32'h0});
    s0_req = 1'b0; s1_req = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
